// File: rtl/dac_filter_tdm.sv
// N-channel TDM cascade of first-order IIR low-pass stages with channel-tagged and framed outputs.
// Latency NUM_STAGES+1 cycles; one sample per cycle, no backpressure; bad channels and clear drop samples.
module dac_filter_tdm #(
  parameter int NUM_CH     = 2,
  parameter int NUM_STAGES = 4,
  parameter int IN_WIDTH   = 16,
  parameter int COEFF_BITS = 27,
  parameter int STATE_BITS = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int CH_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         bypass,
  input  logic signed [COEFF_BITS-1:0] alpha,
  input  logic signed [IN_WIDTH-1:0]   signal_in,
  input  logic [CH_BITS-1:0]           in_ch,
  input  logic                         in_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic [CH_BITS-1:0]           out_ch,
  output logic                         out_valid,
  output logic [NUM_CH*OUT_WIDTH-1:0]  frame_out,
  output logic                         frame_valid,
  output logic                         err_ch
);
  localparam int SB = STATE_BITS;
  localparam int CB = COEFF_BITS;
  localparam int CI = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Index s carries the sample entering stage s; index NUM_STAGES feeds the output register.
  logic signed [SB-1:0] x_bus   [NUM_STAGES+1];
  logic [CH_BITS-1:0]   ch_bus  [NUM_STAGES+1];
  logic                 vld_bus [NUM_STAGES+1];
  logic signed [CB-1:0] a_bus   [NUM_STAGES+1];
  logic                 byp_bus [NUM_STAGES+1];

  logic signed [CB-1:0] alpha_l, alpha_pos;
  logic                 bypass_l, ch_ok, take, take_ch0;

  assign ch_ok     = int'(in_ch) < NUM_CH;
  assign take      = in_valid && !clear && ch_ok;
  assign take_ch0  = take && (in_ch == '0);
  assign alpha_pos = alpha[CB-1] ? '0 : alpha;

  // A channel-0 sample already uses the coefficient it brings; it then holds for the frame.
  assign vld_bus[0] = take;
  assign x_bus[0]   = SB'(signal_in) <<< (SB - IN_WIDTH);
  assign ch_bus[0]  = in_ch;
  assign a_bus[0]   = take_ch0 ? alpha_pos : alpha_l;
  assign byp_bus[0] = take_ch0 ? bypass : bypass_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alpha_l  <= '0;
      bypass_l <= 1'b0;
    end else if (take_ch0) begin
      alpha_l  <= alpha_pos;
      bypass_l <= bypass;
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic signed [SB-1:0]    y_mem [NUM_CH];
    logic signed [SB-1:0]    y_old, y_new, dat_q;
    logic signed [SB:0]      d;
    logic signed [SB+CB:0]   p;
    logic [CH_BITS-1:0]      ch_q;
    logic signed [CB-1:0]    a_q;
    logic                    vld_q, byp_q;

    always_comb begin
      y_old = y_mem[ch_bus[s][CI-1:0]];
      d     = {x_bus[s][SB-1], x_bus[s]} - {y_old[SB-1], y_old};
      p     = d * a_bus[s];
      y_new = byp_bus[s] ? x_bus[s] : y_old + SB'(p >>> (CB - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        ch_q  <= '0;
        a_q   <= '0;
        byp_q <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) y_mem[c] <= '0;
      end else if (clear) begin
        vld_q <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) y_mem[c] <= '0;
      end else begin
        vld_q <= vld_bus[s];
        if (vld_bus[s]) begin
          dat_q <= y_new;
          ch_q  <= ch_bus[s];
          a_q   <= a_bus[s];
          byp_q <= byp_bus[s];
          y_mem[ch_bus[s][CI-1:0]] <= y_new;
        end
      end
    end

    assign x_bus[s+1]   = dat_q;
    assign ch_bus[s+1]  = ch_q;
    assign vld_bus[s+1] = vld_q;
    assign a_bus[s+1]   = a_q;
    assign byp_bus[s+1] = byp_q;
  end

  logic signed [OUT_WIDTH-1:0] conv;

  if (OUT_WIDTH == SB) begin : g_pass
    assign conv = x_bus[NUM_STAGES];
  end else begin : g_round
    localparam logic [SB:0] HALF = (SB+1)'(1) << (SB - OUT_WIDTH - 1);
    logic signed [SB:0]        r;
    logic signed [OUT_WIDTH:0] top;
    assign r    = {x_bus[NUM_STAGES][SB-1], x_bus[NUM_STAGES]} + HALF;
    assign top  = (OUT_WIDTH+1)'(r >>> (SB - OUT_WIDTH));
    // Disagreeing top two bits mean the rounded value left the output range.
    assign conv = (top[OUT_WIDTH] != top[OUT_WIDTH-1]) ?
                  {top[OUT_WIDTH], {(OUT_WIDTH-1){~top[OUT_WIDTH]}}} : top[OUT_WIDTH-1:0];
  end

  logic [NUM_CH*OUT_WIDTH-1:0] shadow, shadow_m;
  logic                        frame_last;

  assign frame_last = vld_bus[NUM_STAGES] && (ch_bus[NUM_STAGES] == CH_BITS'(NUM_CH - 1));

  always_comb begin
    shadow_m = shadow;
    shadow_m[int'(ch_bus[NUM_STAGES][CI-1:0]) * OUT_WIDTH +: OUT_WIDTH] = conv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data    <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      err_ch      <= 1'b0;
      shadow      <= '0;
    end else begin
      err_ch <= in_valid && !clear && !ch_ok;
      if (clear) begin
        out_valid   <= 1'b0;
        frame_valid <= 1'b0;
      end else begin
        out_valid   <= vld_bus[NUM_STAGES];
        frame_valid <= frame_last;
        if (vld_bus[NUM_STAGES]) begin
          out_data <= conv;
          out_ch   <= ch_bus[NUM_STAGES];
          shadow   <= shadow_m;
          if (frame_last) frame_out <= shadow_m;
        end
      end
    end
  end
endmodule

// File: tb/tb_dac_filter_tdm.sv
// Scoreboard bench for dac_filter_tdm: a 4-stage, 2-channel instance checked against a reference
// model, plus a 1-stage instance sharing the inputs for exact step-response values.
module tb_dac_filter_tdm;
  localparam int NC = 2;
  localparam int NS = 4;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, bypass = 1'b0, in_valid = 1'b0;
  logic signed [26:0] alpha = '0;
  logic signed [15:0] signal_in = '0;
  logic [1:0]         in_ch = '0;

  logic signed [15:0] out_data, u1_out_data;
  logic [1:0]         out_ch, u1_out_ch;
  logic               out_valid, frame_valid, err_ch;
  logic               u1_out_valid, u1_frame_valid, u1_err_ch;
  logic [31:0]        frame_out, u1_frame_out;

  always #5 clk = ~clk;

  dac_filter_tdm #(.NUM_CH(NC), .NUM_STAGES(NS), .CH_BITS(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .alpha(alpha),
    .signal_in(signal_in), .in_ch(in_ch), .in_valid(in_valid),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .frame_out(frame_out), .frame_valid(frame_valid), .err_ch(err_ch));

  dac_filter_tdm #(.NUM_CH(NC), .NUM_STAGES(1), .CH_BITS(2)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .alpha(alpha),
    .signal_in(signal_in), .in_ch(in_ch), .in_valid(in_valid),
    .out_data(u1_out_data), .out_ch(u1_out_ch), .out_valid(u1_out_valid),
    .frame_out(u1_frame_out), .frame_valid(u1_frame_valid), .err_ch(u1_err_ch));

  typedef struct {
    int     due;
    int     ch;
    longint dat;
  } exp_t;

  exp_t   q[$], q1[$];
  longint ym [NS][NC];
  longint sh [NC];
  longint al;
  bit     bl, exp_err;
  int     cyc, n_chk, n_pass;

  task automatic check(string tag, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    foreach (ym[s, c]) ym[s][c] = 0;
  endtask

  // Reference filter: y += alpha*(x-y) per stage, then round half-up and saturate to 16 bits.
  task automatic accept(int ch, int x);
    longint v, d, p;
    exp_t   e;
    v = longint'(x) <<< 16;
    for (int s = 0; s < NS; s++) begin
      if (!bl) begin
        d = v - ym[s][ch];
        p = d * al;
        v = ym[s][ch] + (p >>> 26);
        v = longint'(int'(v));
      end
      ym[s][ch] = v;
    end
    v = (v + 32768) >>> 16;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    e.due = cyc + NS + 1;
    e.ch  = ch;
    e.dat = v;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] fexp;
    check("err_ch", err_ch, exp_err);
    if (out_valid) begin
      if (q.size() == 0) check("spurious out_valid", q.size(), 1);
      else begin
        e = q.pop_front();
        check("out_data", out_data, e.dat);
        check("out_ch", out_ch, e.ch);
        check("latency", cyc, e.due);
        sh[e.ch] = e.dat;
        check("frame_valid", frame_valid, e.ch == NC - 1);
        if (e.ch == NC - 1) begin
          fexp = {16'(sh[1]), 16'(sh[0])};
          check("frame_out", frame_out, fexp);
        end
      end
    end else begin
      check("frame_valid idle", frame_valid, 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing out_valid", out_valid, 1);
        void'(q.pop_front());
      end
    end
    if (u1_out_valid && q1.size() > 0) begin
      e = q1.pop_front();
      check("step out_data", u1_out_data, e.dat);
      check("step latency", cyc, e.due);
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      check("step missing", u1_out_valid, 1);
      void'(q1.pop_front());
    end
  endtask

  task automatic tick(bit v, int ch, int x, int a, bit b, bit c);
    @(negedge clk);
    cyc++;
    monitor();
    in_valid  = v;
    in_ch     = 2'(ch);
    signal_in = 16'(x);
    alpha     = 27'(a);
    bypass    = b;
    clear     = c;
    exp_err   = v && !c && (ch >= NC);
    if (c) model_reset();
    else if (v && ch < NC) begin
      if (ch == 0) begin
        al = (a < 0) ? 0 : a;
        bl = b;
      end
      accept(ch, x);
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " out_ch"}, out_ch, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " frame_out"}, frame_out, 0);
    check({tag, " frame_valid"}, frame_valid, 0);
    check({tag, " err_ch"}, err_ch, 0);
  endtask

  localparam int A_HALF = 1 << 25;
  localparam int A_QTR  = 1 << 24;

  initial begin
    longint step_tbl [6] = '{8192, 12288, 14336, 15360, 15872, 16128};
    int r, a, x;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Step response on channel 0 (also exercises same-channel back-to-back).
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 16384, A_HALF, 0, 0);
      q1.push_back('{cyc + 2, 0, step_tbl[k]});
    end
    repeat (8) tick(0, 0, 0, 0, 0, 0);

    // Clear with a valid sample in the same cycle, then opposite constant inputs.
    tick(1, 0, 1234, A_HALF, 0, 1);
    for (int k = 0; k < 20; k++) begin
      tick(1, 0, 16384, A_HALF, 0, 0);
      tick(1, 1, -16384, A_HALF, 0, 0);
    end

    // Coefficient change while channel 1 is presented takes effect at the next frame.
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 3000 * k - 5000, A_HALF, 0, 0);
      tick(1, 1, 20000 - 7000 * k, A_QTR, 0, 0);
      tick(1, 0, -12000 + 4000 * k, A_QTR, 0, 0);
      tick(1, 1, 9000, A_HALF, 0, 0);
    end

    // Bypass on at full negative scale, then off with the same input.
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, -32768, A_HALF, 1, 0);
      tick(1, 1, -32768, A_HALF, 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, -32768, A_HALF, 0, 0);
      tick(1, 1, -32768, A_HALF, 0, 0);
    end

    // Random traffic: gaps, bad channel 2, negative alphas, occasional bypass.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, (1 << 27) - 1);
      a = (r >= (1 << 26)) ? r - (1 << 27) : r;
      x = $urandom_range(0, 65535) - 32768;
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2), x, a,
           $urandom_range(0, 3) == 0, 0);
    end

    // Clear with three samples in flight, then a bad channel.
    tick(1, 0, 30000, A_HALF, 0, 0);
    tick(1, 1, -30000, A_HALF, 0, 0);
    tick(1, 0, 25000, A_HALF, 0, 0);
    tick(1, 1, 777, A_HALF, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 3, 5555, A_HALF, 0, 0);
    tick(1, 0, 16384, A_HALF, 0, 0);
    tick(1, 1, 16384, A_HALF, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 10000, A_HALF, 0, 0);
      tick(1, 1, -10000, A_HALF, 0, 0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid reset");
    in_valid = 1'b0;
    model_reset();
    al = 0;
    bl = 0;
    exp_err = 0;
    foreach (sh[c]) sh[c] = 0;
    repeat (2) tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1, 0, 16384, A_HALF, 0, 0);
    q1.push_back('{cyc + 2, 0, 8192});
    tick(1, 1, 16384, A_HALF, 0, 0);

    repeat (NS + 4) tick(0, 0, 0, 0, 0, 0);
    check("scoreboard drained", q.size(), 0);
    check("step scoreboard drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
